// File: rtl/deser_lane_src.sv
// ADC deserializer lane source: registered live/test-pattern lane output plus a
// single-channel snapshot buffer drained through a read handshake.
module deser_lane_src #(
    parameter int NUM_CH    = 32,
    parameter int DATA_W    = 6,
    parameter int CAP_DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-1:0]          const_val,
    input  logic [NUM_CH*DATA_W-1:0]   idat,
    output logic [NUM_CH*DATA_W-1:0]   odat,
    output logic                       odat_valid,
    input  logic                       cap_start,
    input  logic [$clog2(NUM_CH)-1:0]  cap_ch,
    output logic                       cap_busy,
    output logic                       cap_done,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid
);

    localparam int TOT_W = NUM_CH * DATA_W;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(CAP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CAP_DEPTH - 1);
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } cap_state_t;

    // Runs x^7+x^6+1 for a whole lane word, bit 0 first; returns {next_state, bits}.
    function automatic logic [TOT_W+6:0] prbs_gen(input logic [6:0] seed);
        logic [6:0]       s;
        logic [TOT_W-1:0] b;
        logic             o;
        s = seed;
        b = '0;
        for (int i = 0; i < TOT_W; i++) begin
            o    = s[6] ^ s[5];
            b[i] = o;
            s    = {s[5:0], o};
        end
        return {s, b};
    endfunction

    function automatic logic [TOT_W-1:0] ramp_gen(input logic [DATA_W-1:0] base);
        logic [TOT_W-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w[k*DATA_W +: DATA_W] = base + DATA_W'(k);
        end
        return w;
    endfunction

    logic [1:0]         mode_r;
    logic [DATA_W-1:0]  base_r;
    logic [6:0]         lfsr_r;
    logic [TOT_W-1:0]   odat_r;
    logic               odat_valid_r;

    logic               mode_chg_s;
    logic [DATA_W-1:0]  base_s;
    logic [6:0]         lfsr_s;
    logic [6:0]         lfsr_nxt_s;
    logic [TOT_W-1:0]   prbs_bits_s;
    logic [TOT_W-1:0]   sel_s;

    cap_state_t         state_r;
    logic [CH_W-1:0]    ch_r;
    logic [CH_W-1:0]    ch_sel_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic               cap_busy_r;
    logic               cap_done_r;
    logic [DATA_W-1:0]  rd_data_r;
    logic               rd_valid_r;
    logic               cap_wr_s;
    logic [DATA_W-1:0]  cap_word_s;
    logic [DATA_W-1:0]  cap_mem_r [CAP_DEPTH];

    // Pattern selection; a mode change substitutes the fresh seed in the same cycle.
    always_comb begin
        mode_chg_s = (mode != mode_r);
        base_s     = mode_chg_s ? '0 : base_r;
        lfsr_s     = mode_chg_s ? PRBS_SEED : lfsr_r;
        {lfsr_nxt_s, prbs_bits_s} = prbs_gen(lfsr_s);
        case (mode)
            2'd0:    sel_s = idat;
            2'd1:    sel_s = ramp_gen(base_s);
            2'd2:    sel_s = prbs_bits_s;
            2'd3:    sel_s = {NUM_CH{const_val}};
            default: sel_s = idat;
        endcase
    end

    // Lane output register and generator state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r       <= 2'd0;
            base_r       <= '0;
            lfsr_r       <= PRBS_SEED;
            odat_r       <= '0;
            odat_valid_r <= 1'b0;
        end else begin
            mode_r <= mode;
            if (en) begin
                odat_r       <= sel_s;
                odat_valid_r <= 1'b1;
                base_r       <= (mode == 2'd1) ? base_s + DATA_W'(NUM_CH) : base_s;
                lfsr_r       <= (mode == 2'd2) ? lfsr_nxt_s : lfsr_s;
            end else begin
                odat_valid_r <= 1'b0;
                base_r       <= base_s;
                lfsr_r       <= lfsr_s;
            end
        end
    end

    // Snapshot channel select and write strobe; out-of-range channels fall back to 0.
    always_comb begin
        if ({1'b0, cap_ch} < (CH_W+1)'(NUM_CH)) begin
            ch_sel_s = cap_ch;
        end else begin
            ch_sel_s = '0;
        end
        cap_wr_s   = (state_r == ST_FILL) && odat_valid_r;
        cap_word_s = odat_r[ch_r*DATA_W +: DATA_W];
    end

    // Snapshot storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (cap_wr_s) begin
            cap_mem_r[wr_ptr_r] <= cap_word_s;
        end
    end

    // Snapshot FSM: IDLE -> FILL (CAP_DEPTH valid words) -> DONE (CAP_DEPTH reads).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ch_r       <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cap_busy_r <= 1'b0;
            cap_done_r <= 1'b0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cap_start) begin
                        state_r    <= ST_FILL;
                        ch_r       <= ch_sel_s;
                        wr_ptr_r   <= '0;
                        cap_busy_r <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (odat_valid_r) begin
                        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                        if (wr_ptr_r == LAST_PTR) begin
                            state_r    <= ST_DONE;
                            rd_ptr_r   <= '0;
                            cap_busy_r <= 1'b0;
                            cap_done_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_en) begin
                        rd_data_r  <= cap_mem_r[rd_ptr_r];
                        rd_valid_r <= 1'b1;
                        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                        if (rd_ptr_r == LAST_PTR) begin
                            state_r    <= ST_IDLE;
                            cap_done_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cap_busy_r <= 1'b0;
                    cap_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign odat       = odat_r;
    assign odat_valid = odat_valid_r;
    assign cap_busy   = cap_busy_r;
    assign cap_done   = cap_done_r;
    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;

endmodule
